// File: rtl/bus_mem_responder.sv
// Fixed-latency word-addressed memory target for the core's memory bus.
// Serves one read or write at a time and holds bus_full while busy.
module bus_mem_responder #(
  parameter int unsigned WORDS   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_in,
  input  logic [31:0] data_in,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [3:0]  byte_en,
  output logic [31:0] data_out_BUS,
  output logic        bus_full,
  output logic        resp_valid,
  output logic        addr_err
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:2]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          wr_q;
  logic [31:0]   mem_q [WORDS];
  logic [31:0]   rdata_q, rdata_d;
  logic          resp_q, resp_d;
  logic          err_q, err_d;
  logic          full_q, full_d;

  logic          req;
  logic          accept;
  logic          access;
  logic          oor;
  logic [AW-1:0] idx;

  assign req    = read_en | write_en;
  assign accept = (state_q == IDLE) && req;
  assign idx    = addr_q[AW+1:2];
  assign oor    = |addr_q[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    err_d   = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = WAIT;
          cnt_d   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESPOND;
          resp_d  = 1'b1;
          err_d   = oor;
          if (!wr_q) begin
            rdata_d = oor ? '0 : mem_q[idx];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    full_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      full_q  <= full_d;
    end
  end

  // A request with both enables set is a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= address_in[31:2];
      wdata_q <= data_in;
      be_q    <= byte_en;
      wr_q    <= write_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (access && wr_q && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign data_out_BUS = rdata_q;
  assign bus_full     = full_q;
  assign resp_valid   = resp_q;
  assign addr_err     = err_q;

endmodule
